// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter with a start/done handshake. A value is loaded while
// idle, start launches the countdown, and count decrements it while running.
// A one-cycle done pulse marks terminal count.
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//   When this macro is defined, the last loaded value is reloaded from DONE and
//   the countdown repeats. The timer stops only on reset.
//
// Parameters:
//   WIDTH     width of the count register and load_val
// Ports:
//   clk       clock; all state changes happen on the rising edge
//   reset     synchronous reset, active low
//   load      in IDLE, capture load_val into out
//   load_val  value to load
//   start     in IDLE, begin the countdown
//   count     decrement enable while running
//   out       current count value (registered)
//   busy      high while in RUN (registered)
//   done      one-cycle terminal-count pulse (registered)
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             count,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_done;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
`endif

    // Decrement: out + all-ones through a ripple-carry chain. The final
    // carry-out is never formed because it is discarded.
    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_dec;

    assign w_ones     = {WIDTH{1'b1}};
    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < int'(WIDTH); gi++) begin : g_rca
            assign w_dec[gi] = r_out[gi] ^ w_ones[gi] ^ w_carry[gi];
            if (gi < int'(WIDTH) - 1) begin : g_carry
                assign w_carry[gi+1] = (r_out[gi] & w_ones[gi])
                                     | (r_out[gi] & w_carry[gi])
                                     | (w_ones[gi] & w_carry[gi]);
            end
        end
    endgenerate

    // State machine; busy and done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // When load and start are both high, load takes priority.
                    if (load) begin
                        r_out <= load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        r_reload <= load_val;
`endif
                    end else if (start) begin
                        if (r_out != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    // out is at least 1 in RUN, so the count cannot wrap.
                    if (count) begin
                        r_out <= w_dec;
                        if (r_out == WIDTH'(1)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    r_out <= r_reload;
                    if (r_reload != '0) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_out   <= '0;
                    r_state <= S_IDLE;
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with start/done handshake: the counting-down counterpart of the team's 4-bit up counter. A value is loaded while idle, `start` launches a countdown that decrements on each enabled clock, and a one-cycle `done` pulse marks terminal count. It serves as the timeout/delay generator beside the up counter in the same clock domain.

## Interface
Parameters:
- `WIDTH`, default 4, width of the count register and `load_val`.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset, synchronous, active-low; clock clk.
- `load`  input  1  in IDLE, capture `load_val` into `out`.
- `load_val`  input  WIDTH  value to load.
- `start`  input  1  in IDLE, begin the countdown.
- `count`  input  1  decrement enable while running.
- `out`  output  WIDTH  current count value, registered.
- `busy`  output  1  high while in RUN, registered.
- `done`  output  1  one-cycle terminal-count pulse, registered.

## Operation
- States: IDLE, RUN, DONE. `busy` = (state==RUN); `done` = (state==DONE).
- Reset (`reset`==0 at an edge): state IDLE, `out`=0, `busy`=0, `done`=0. Overrides every other input, including mid-RUN; an aborted countdown produces no `done`.
- IDLE:
  - `load`=1 sets `out`<=`load_val`; state stays IDLE.
  - `start`=1 with `load`=0 and `out`!=0 moves to RUN.
  - `start`=1 with `load`=0 and `out`==0 moves straight to DONE.
  - `load` and `start` together: load wins and start is ignored.
  - `count` is ignored.
- RUN:
  - `count`=1 sets `out`<=`out`-1.
  - `count`=1 with `out`==1 sets `out`<=0 and moves to DONE.
  - `count`=0 holds `out` and state.
  - `load` and `start` are ignored.
- DONE: lasts exactly one cycle, then moves to IDLE; `out` holds 0 and all inputs are ignored.
- Arithmetic:
  - Decrement is `out` + all-ones (WIDTH bits) through a WIDTH-bit ripple-carry chain; the carry-out is discarded.
  - Underflow is impossible: decrement happens only in RUN with `out`>=1, so there is no wrap from 0 to 2^WIDTH-1.

## Timing
- `start` sampled at edge N with `out`=V>0: `busy`=1 after edge N.
- With `count` held high, `out` reads V-1 after edge N+1 and 0 after edge N+V.
- `done`=1 and `busy`=0 during the cycle after edge N+V; `done` falls after edge N+V+1.
- `busy` is high for exactly V cycles when `count` is continuous; each `count`=0 cycle extends RUN by one cycle.
- `start` with `out`=0 at edge N: `done` is high for the single cycle after edge N and `busy` never rises.
- Load-to-start latency is at least one cycle: a value loaded at edge N can be started at edge N+1.
- No combinational path from inputs to outputs.

## Configuration
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - An internal WIDTH-bit reload register captures `load_val` on every accepted load; it resets to 0.
  - In DONE, `out`<=reload. Next state is RUN if reload!=0, else IDLE.
  - The countdown repeats, with `done` pulsing once per period of reload+1 cycles under continuous `count`.
  - Only reset or an IDLE-state load changes the period; to stop, the system asserts reset.
- Undefined: no reload register; DONE always returns to IDLE with `out`=0 (behaviour above).

## Test plan
- Reset then idle: after `reset` low for 1 edge, `out`=0, `busy`=0, `done`=0; `count`=1 in IDLE leaves `out`=0.
- Basic countdown, WIDTH=4: load 5, start, `count` held high -> `out` goes 5,4,3,2,1,0; `busy` is high 5 cycles; `done` is high exactly 1 cycle, then IDLE.
- Gapped enable: load 3, start, `count` toggling 1,0,1,0,1 -> `done` appears after the third enabled edge; `busy` is high 5 cycles.
- Edge cases:
  - Start with `out`=0 -> immediate single `done`, no `busy`.
  - `load`+`start` same cycle with `load_val`=7 -> `out`=7 and state stays IDLE.
  - Load 15 -> full-scale count of 15 steps with no wrap.
- Reset mid-RUN: load 9, start, 4 decrements, pull `reset` low -> `out`=0, `busy`=0, and no `done` ever asserted.
- With `COUNTDOWN_AUTO_RELOAD_EN`: load 2, start, continuous `count` -> `out` sequence 2,1,0,2,1,0,...; `done` pulses every 3 cycles; reset stops it.
